// File: rtl/axis_tbcall_pkg.sv
// axis_tbcall_pkg
// Shared definitions for the emulator task-call responder.
//   - state_e       : responder FSM states (IDLE, REQ, WAIT, RET)
//   - *_DEF         : default widths and default host-return timeout
package axis_tbcall_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;
  localparam int TMO_W_DEF  = 16;

  // Default number of WAIT cycles before a missing host return is forced
  localparam logic [15:0] TMO_CYC_DEF = 16'd4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RET  = 2'd3
  } state_e;

endpackage

// File: rtl/axis_tbcall_resp_tmr.sv
// axis_tbcall_resp_tmr
// Up-counter used as the host-return watchdog.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : load the counter with zero (wins over en_i)
//   en_i       : advance the counter by one
//   limit_i    : terminal value + 1; zero disables the terminal flag
//   tc_o       : high while the count sits on limit_i-1 and the limit is non-zero
module axis_tbcall_resp_tmr
  import axis_tbcall_pkg::*;
#(
  parameter int W = TMO_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority so the FSM can restart the window
  // on the same cycle it would otherwise keep counting.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit means the watchdog never fires.
  assign tc_o = (limit_i != '0) && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/axis_tbcall_resp.sv
// axis_tbcall_resp
// Responder end of the emulator task-call channel. A one-cycle call strobe
// from an initiator is turned into a host request (valid/ready), the design
// is held stopped until the tagged host return arrives (or the watchdog
// fires), and the return value is handed back with a one-cycle strobe.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   call_req, call_arg              : call strobe and argument from initiator
//   host_req_valid/ready/id/arg     : request channel towards the host
//   host_ret_valid/id/data          : tagged return from the host
//   stop_out                        : holds emulation while a call is open
//   ret_valid, ret_data             : return strobe and value into the design
//   err_timeout, err_id, err_overrun: sticky error flags
//   err_clr                         : clears all sticky flags
module axis_tbcall_resp
  import axis_tbcall_pkg::*;
#(
  parameter int               DATA_W  = DATA_W_DEF,
  parameter int               ID_W    = ID_W_DEF,
  parameter int               TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic [DATA_W-1:0] call_arg,
  output logic              host_req_valid,
  input  logic              host_req_ready,
  output logic [ID_W-1:0]   host_req_id,
  output logic [DATA_W-1:0] host_req_arg,
  input  logic              host_ret_valid,
  input  logic [ID_W-1:0]   host_ret_id,
  input  logic [DATA_W-1:0] host_ret_data,
  output logic              stop_out,
  output logic              ret_valid,
  output logic [DATA_W-1:0] ret_data,
  output logic              err_timeout,
  output logic              err_id,
  output logic              err_overrun,
  input  logic              err_clr
);

  state_e            state_q,      state_d;
  logic [ID_W-1:0]   seq_q,        seq_d;
  logic [ID_W-1:0]   tag_q,        tag_d;
  logic [DATA_W-1:0] reqArg_q,     reqArg_d;
  logic              pendFull_q,   pendFull_d;
  logic [DATA_W-1:0] pendArg_q,    pendArg_d;
  logic [DATA_W-1:0] retData_q,    retData_d;
  logic              errTimeout_q, errTimeout_d;
  logic              errId_q,      errId_d;
  logic              errOverrun_q, errOverrun_d;

  logic timerClr;
  logic timerEn;
  logic timerTc;
  logic retMatch;
  logic setTimeout;
  logic setId;
  logic setOverrun;

  // The watchdog only runs while waiting for the host; it is held at zero
  // everywhere else so each WAIT phase starts a fresh window.
  axis_tbcall_resp_tmr #(
    .W (TMO_W)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (timerClr),
    .en_i    (timerEn),
    .limit_i (TMO_CYC),
    .tc_o    (timerTc)
  );

  assign retMatch = host_ret_valid && (host_ret_id == tag_q);

  // Next-state logic for the call FSM, the pending slot and error events.
  // Issuing a call always takes the current sequence number as the tag and
  // advances the sequence, whether the call comes straight from call_req
  // or out of the pending slot.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    tag_d      = tag_q;
    reqArg_d   = reqArg_q;
    pendFull_d = pendFull_q;
    pendArg_d  = pendArg_q;
    retData_d  = retData_q;
    timerClr   = 1'b0;
    timerEn    = 1'b0;
    setTimeout = 1'b0;
    setId      = 1'b0;
    setOverrun = 1'b0;

    case (state_q)
      IDLE: begin
        timerClr = 1'b1;
        if (call_req) begin
          tag_d    = seq_q;
          seq_d    = seq_q + ID_W'(1);
          reqArg_d = call_arg;
          state_d  = REQ;
        end
      end

      REQ: begin
        timerClr = 1'b1;
        if (host_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        timerEn = 1'b1;
        // A matching return beats a same-cycle timeout.
        if (retMatch) begin
          retData_d = host_ret_data;
          state_d   = RET;
        end else begin
          if (host_ret_valid) begin
            setId = 1'b1;
          end
          if (timerTc) begin
            setTimeout = 1'b1;
            retData_d  = '0;
            state_d    = RET;
          end
        end
      end

      RET: begin
        timerClr = 1'b1;
        // A call arriving in RET with an empty slot is a slot fill that is
        // consumed immediately, so it goes straight out as the next request.
        if (pendFull_q) begin
          tag_d      = seq_q;
          seq_d      = seq_q + ID_W'(1);
          reqArg_d   = pendArg_q;
          pendFull_d = 1'b0;
          state_d    = REQ;
        end else if (call_req) begin
          tag_d    = seq_q;
          seq_d    = seq_q + ID_W'(1);
          reqArg_d = call_arg;
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Calls outside IDLE park in the one-deep slot; a second one is dropped.
    if (call_req && (state_q != IDLE)) begin
      if (pendFull_q) begin
        setOverrun = 1'b1;
      end else if (state_q != RET) begin
        pendFull_d = 1'b1;
        pendArg_d  = call_arg;
      end
    end
  end

  // Sticky errors: a clear in the same cycle as an error event wins and the
  // event is lost.
  always_comb begin
    errTimeout_d = err_clr ? 1'b0 : (errTimeout_q | setTimeout);
    errId_d      = err_clr ? 1'b0 : (errId_q      | setId);
    errOverrun_d = err_clr ? 1'b0 : (errOverrun_q | setOverrun);
  end

  // State registers. Reset discards both the outstanding and pending call.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      tag_q        <= '0;
      reqArg_q     <= '0;
      pendFull_q   <= 1'b0;
      pendArg_q    <= '0;
      retData_q    <= '0;
      errTimeout_q <= 1'b0;
      errId_q      <= 1'b0;
      errOverrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      tag_q        <= tag_d;
      reqArg_q     <= reqArg_d;
      pendFull_q   <= pendFull_d;
      pendArg_q    <= pendArg_d;
      retData_q    <= retData_d;
      errTimeout_q <= errTimeout_d;
      errId_q      <= errId_d;
      errOverrun_q <= errOverrun_d;
    end
  end

  // Handshake and stop outputs decode straight from the state register so
  // that reset drops them asynchronously.
  assign host_req_valid = (state_q == REQ);
  assign stop_out       = (state_q == REQ) || (state_q == WAIT);
  assign ret_valid      = (state_q == RET);
  assign host_req_id    = tag_q;
  assign host_req_arg   = reqArg_q;
  assign ret_data       = retData_q;
  assign err_timeout    = errTimeout_q;
  assign err_id         = errId_q;
  assign err_overrun    = errOverrun_q;

endmodule

// File: tb/tb_axis_tbcall_resp.sv
// Self-checking bench for axis_tbcall_resp: expected requests and returns are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_axis_tbcall_resp;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int TMO_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              call_req;
  logic [DATA_W-1:0] call_arg;
  logic              host_req_valid;
  logic              host_req_ready;
  logic [ID_W-1:0]   host_req_id;
  logic [DATA_W-1:0] host_req_arg;
  logic              host_ret_valid;
  logic [ID_W-1:0]   host_ret_id;
  logic [DATA_W-1:0] host_ret_data;
  logic              stop_out;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_data;
  logic              err_timeout;
  logic              err_id;
  logic              err_overrun;
  logic              err_clr;

  int nChecks = 0;
  int nPass   = 0;
  int retSeen = 0;
  int retMark;

  logic [ID_W+DATA_W-1:0] expReq[$];
  logic [DATA_W-1:0]      expRet[$];
  logic [ID_W+DATA_W-1:0] reqHead;
  logic [DATA_W-1:0]      retHead;
  logic [ID_W-1:0]        modelSeq;

  axis_tbcall_resp #(
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .TMO_W   (TMO_W),
    .TMO_CYC (16'd8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .call_req       (call_req),
    .call_arg       (call_arg),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_id    (host_req_id),
    .host_req_arg   (host_req_arg),
    .host_ret_valid (host_ret_valid),
    .host_ret_id    (host_ret_id),
    .host_ret_data  (host_ret_data),
    .stop_out       (stop_out),
    .ret_valid      (ret_valid),
    .ret_data       (ret_data),
    .err_timeout    (err_timeout),
    .err_id         (err_id),
    .err_overrun    (err_overrun),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      nPass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one call strobe; when the call is expected to be issued, queue
  // the request the host should see with the bench's own tag counter.
  task automatic applyStimulus(input logic [DATA_W-1:0] arg, input bit expectIssue);
    call_req = 1'b1;
    call_arg = arg;
    if (expectIssue) begin
      expReq.push_back({modelSeq, arg});
      modelSeq = modelSeq + 1'b1;
    end
    tick();
    call_req = 1'b0;
  endtask

  task automatic driveRet(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data, input bit expectMatch);
    host_ret_valid = 1'b1;
    host_ret_id    = id;
    host_ret_data  = data;
    if (expectMatch) expRet.push_back(data);
    tick();
    host_ret_valid = 1'b0;
  endtask

  task automatic clearErrors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_req_valid && host_req_ready) begin
        if (expReq.size() == 0) begin
          checkOutput("req_unexpected", host_req_valid, 0);
        end else begin
          reqHead = expReq.pop_front();
          checkOutput("req_id_arg", {host_req_id, host_req_arg}, reqHead);
        end
      end
      if (ret_valid) begin
        retSeen++;
        checkOutput("ret_stop_low", stop_out, 0);
        if (expRet.size() == 0) begin
          checkOutput("ret_unexpected", ret_valid, 0);
        end else begin
          retHead = expRet.pop_front();
          checkOutput("ret_data", ret_data, retHead);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    call_req       = 1'b0;
    call_arg       = '0;
    host_req_ready = 1'b0;
    host_ret_valid = 1'b0;
    host_ret_id    = '0;
    host_ret_data  = '0;
    err_clr        = 1'b0;
    modelSeq       = '0;

    // Reset state
    repeat (2) tick();
    checkOutput("rst_stop", stop_out, 0);
    checkOutput("rst_req_valid", host_req_valid, 0);
    checkOutput("rst_ret_valid", ret_valid, 0);
    checkOutput("rst_outputs", {host_req_id, host_req_arg, ret_data}, 0);
    checkOutput("rst_errors", {err_timeout, err_id, err_overrun}, 0);
    rst_n = 1'b1;
    tick();

    // Basic call: ready after 2 cycles, return after 5 WAIT cycles
    $display("[TB] basic call");
    applyStimulus(32'h1234, 1);
    checkOutput("basic_req_valid", host_req_valid, 1);
    checkOutput("basic_stop", stop_out, 1);
    checkOutput("basic_req_id", host_req_id, 0);
    tick();
    tick();
    host_req_ready = 1'b1;
    tick();
    host_req_ready = 1'b0;
    checkOutput("basic_wait_stop", stop_out, 1);
    repeat (4) tick();
    driveRet(4'd0, 32'hCAFE, 1);
    checkOutput("basic_ret_valid", ret_valid, 1);
    checkOutput("basic_ret_stop", stop_out, 0);
    tick();
    checkOutput("basic_ret_pulse", ret_valid, 0);
    checkOutput("basic_ret_hold", ret_data, 32'hCAFE);

    // Back-to-back calls with a pending slot, then an overrun
    $display("[TB] back-to-back");
    applyStimulus(32'hA, 1);
    tick();
    applyStimulus(32'hB, 1);
    checkOutput("b2b_overrun_clear", err_overrun, 0);
    host_req_ready = 1'b1;
    tick();
    applyStimulus(32'hC, 0);
    checkOutput("b2b_overrun", err_overrun, 1);
    driveRet(4'd1, 32'h1111, 1);
    checkOutput("b2b_ret1", ret_valid, 1);
    tick();
    checkOutput("b2b_second_valid", host_req_valid, 1);
    checkOutput("b2b_second_id", host_req_id, 2);
    checkOutput("b2b_second_stop", stop_out, 1);
    tick();
    driveRet(4'd2, 32'h2222, 1);
    checkOutput("b2b_ret2", ret_valid, 1);
    tick();
    clearErrors();
    checkOutput("b2b_overrun_cleared", err_overrun, 0);

    // Tag mismatch followed by the matching return
    $display("[TB] tag mismatch");
    retMark = retSeen;
    applyStimulus(32'h33, 1);
    tick();
    driveRet(4'd5, 32'h99, 0);
    checkOutput("mis_stay_wait", stop_out, 1);
    driveRet(4'd3, 32'h55, 1);
    checkOutput("mis_err_id", err_id, 1);
    checkOutput("mis_ret_valid", ret_valid, 1);
    tick();
    tick();
    checkOutput("mis_single_ret", retSeen - retMark, 1);
    clearErrors();

    // Timeout after 8 WAIT cycles, stale return in IDLE ignored
    $display("[TB] timeout");
    applyStimulus(32'h44, 1);
    expRet.push_back(32'h0);
    tick();
    repeat (7) tick();
    checkOutput("tmo_not_yet", err_timeout, 0);
    checkOutput("tmo_not_yet_ret", ret_valid, 0);
    tick();
    checkOutput("tmo_err", err_timeout, 1);
    checkOutput("tmo_ret_valid", ret_valid, 1);
    tick();
    driveRet(4'd0, 32'h77, 0);
    checkOutput("tmo_stale_err_id", err_id, 0);
    checkOutput("tmo_stale_ret", ret_valid, 0);
    checkOutput("tmo_stale_stop", stop_out, 0);
    checkOutput("tmo_ret_zero", ret_data, 0);
    clearErrors();

    // Matching return in the timeout cycle
    $display("[TB] simultaneous events");
    applyStimulus(32'h55, 1);
    tick();
    repeat (7) tick();
    driveRet(4'd5, 32'h5A5A, 1);
    checkOutput("sim_ret_valid", ret_valid, 1);
    checkOutput("sim_no_timeout", err_timeout, 0);
    tick();

    // err_clr concurrent with a mismatching return
    applyStimulus(32'h66, 1);
    tick();
    err_clr = 1'b1;
    driveRet(4'd9, 32'h99, 0);
    err_clr = 1'b0;
    checkOutput("clr_wins_err_id", err_id, 0);
    checkOutput("clr_still_wait", stop_out, 1);
    driveRet(4'd6, 32'h6666, 1);
    checkOutput("clr_ret_valid", ret_valid, 1);
    tick();

    // Reset in WAIT with a sticky error set
    $display("[TB] reset mid-call");
    applyStimulus(32'h77, 1);
    tick();
    driveRet(4'd2, 32'h12, 0);
    checkOutput("rstw_err_id_set", err_id, 1);
    checkOutput("rstw_stop_high", stop_out, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_stop_async", stop_out, 0);
    checkOutput("rstw_errors", {err_timeout, err_id, err_overrun}, 0);
    checkOutput("rstw_req_valid", host_req_valid, 0);
    modelSeq = '0;
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(32'h70, 1);
    checkOutput("rstw_tag_zero", host_req_id, 0);
    tick();
    driveRet(4'd0, 32'h7070, 1);
    checkOutput("rstw_ret_valid", ret_valid, 1);
    tick();
    tick();

    checkOutput("sb_empty", expReq.size() + expRet.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
